wb_serializer: RTL and testbench
================================

Name: wb_serializer

Overview:
- Writeback-side producer for the dual-write-port register file in the superscalar core.
- Accepts up to two retiring results per cycle from pipeline lanes 0/1 (lane 0 is older) and buffers them in program order.
- Drains at most one write per cycle onto the reg-file port pairs (WE3/AD3/WD3 or WE6/AD6/WD6), so the two enables are never asserted together.
- Gives decode a pending-write hazard check.

Parameters:
ADDRESS_WIDTH, 5, register address width (32 regs)
DATA_WIDTH, 32, register data width
DEPTH, 4, queue entries; power of two, >= 2

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
in0_valid  in  1  lane-0 result valid
in0_rd  in  ADDRESS_WIDTH  lane-0 destination
in0_data  in  DATA_WIDTH  lane-0 result
in1_valid  in  1  lane-1 result valid
in1_rd  in  ADDRESS_WIDTH  lane-1 destination
in1_data  in  DATA_WIDTH  lane-1 result
in_ready  out  1  both inputs accepted this cycle
WE3  out  1  reg-file port-3 write enable
AD3  out  ADDRESS_WIDTH  port-3 address
WD3  out  DATA_WIDTH  port-3 data
WE6  out  1  reg-file port-6 write enable
AD6  out  ADDRESS_WIDTH  port-6 address
WD6  out  DATA_WIDTH  port-6 data
chk_addr1  in  ADDRESS_WIDTH  decode rs1 query
chk_addr2  in  ADDRESS_WIDTH  decode rs2 query
chk_hit1  out  1  rs1 has a pending write
chk_hit2  out  1  rs2 has a pending write
count  out  $clog2(DEPTH)+1  occupied entries
empty  out  1  count==0 and no write being driven

Behaviour:
- Reset (async assert, sync release): pointers and count = 0; WE3/WE6 = 0; AD3/AD6/WD3/WD6 = 0; empty = 1.
- in_ready is combinational: (DEPTH - count) >= 2. It ignores same-cycle drain.
- When in_ready = 0, inputs are ignored; the producer holds them.
- Enqueue:
  - Each valid input with rd != 0 is written with its lane tag; lane 0 goes first.
  - Results with rd == 0 are discarded: no entry, never written.
  - in1 alone (in0_valid = 0) is legal.
- Drain:
  - Each posedge with count > 0 pops the head into the output registers. The write is visible the whole following cycle; the reg file commits it on negedge.
  - Lane-0 entry: WE3 = 1, AD3/WD3 = entry, WE6 = 0.
  - Lane-1 entry: WE6 = 1, AD6/WD6 = entry, WE3 = 0, and AD3 is driven equal to AD6. This is required by the reg-file port-6 gating on AD3 != 0.
  - With no pop, both enables = 0 and addresses/data = 0.
- Simultaneous enqueue and pop: count_next = count + accepted_entries - pop.
- Latency: a result accepted at edge N with an empty queue is popped at edge N+1 and written on the following negedge.
- Throughput: 1 write/cycle. Sustained dual issue fills the queue and deasserts in_ready.
- Ordering:
  - Writes leave in strict acceptance order.
  - Two writes to the same rd land oldest-first; the final value is the younger one.
- Wrap-around: circular pointers modulo DEPTH. Full is count == DEPTH; in_ready is 0 once count > DEPTH-2.
- Hazard check (combinational), chk_hitN = 1 if chk_addrN != 0 and any of:
  - a valid queue entry has rd == chk_addrN;
  - the output register currently drives a write to chk_addrN;
  - an input accepted this cycle has rd == chk_addrN.
- Reset mid-operation drops all queued writes; there is no partial write after rst rises.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined: when in0 and in1 are accepted together with equal nonzero rd, only the in1 entry is enqueued (one entry, count +1).
- Undefined: both are enqueued and written oldest-first, using two cycles.
- Hazard and ordering rules are unchanged either way.

Decomposition:
- Package wb_pkg:
  - wb_entry_t struct {lane bit, rd, data}
  - LANE0/LANE1 constants
  - REG_ZERO constant
- Sub-module wb_fifo: circular buffer with dual push, single pop, count, and per-entry rd compare vector for hazard lookup.
- wb_serializer adds input filtering, optional coalescing, output port steering and AD3 mirroring.

Test Plan:
- After rst: in0 {rd=5, data=0xA}, 1 cycle → next cycle WE3=1, AD3=5, WD3=0xA, WE6=0; following cycle both enables 0, empty=1.
- Same cycle in0 {3, 0x11} and in1 {4, 0x22} → cycle +1: WE3 AD3=3; cycle +2: WE6=1, AD6=4, AD3=4, WE3=0; never WE3 and WE6 together.
- in0 {0, 0xFF} plus in1 {7, 0x1} → single entry; only port-6 write to x7; chk_addr1=0 never hits.
- Dual issue every cycle, DEPTH=4 → in_ready falls once count reaches 3; writes continue 1/cycle with no loss or reorder over 20 results across pointer wrap.
- in0 {9, 1} plus in1 {9, 2} → no macro: x9 written 1 then 2. With WB_COALESCE_EN: one write of 2, count peak 1.
- Queue holding rd 6, chk_addr2=6 → chk_hit2=1; rst asserted mid-drain → outputs 0 immediately, count 0, chk_hit2=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback serializer.
//   WB_ADDR_W / WB_DATA_W : entry field widths (32 regs x 32 bits)
//   LANE0 / LANE1         : lane tag values carried in each queued entry
//   REG_ZERO              : hard-wired zero register, never written
//   wb_entry_t            : one queued register-file write
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_DATA_W = 32;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                 lane;
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending register-file writes.
//   clk, rst           : clock, asynchronous active-high reset
//   push_n             : number of entries pushed this cycle (0..2)
//   push_a, push_b     : first / second pushed entry (push_b only when push_n == 2)
//   pop                : remove head this cycle (caller guarantees count > 0)
//   head               : oldest entry
//   count              : occupied entries
//   cmp_addr1/2        : hazard query addresses
//   match1/2           : per-entry "valid and rd == cmp_addr" vectors
// The caller guarantees push_n never exceeds the free space.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             push_n,
  input  wb_entry_t              push_a,
  input  wb_entry_t              push_b,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  input  logic [WB_ADDR_W-1:0]   cmp_addr1,
  input  logic [WB_ADDR_W-1:0]   cmp_addr2,
  output logic [DEPTH-1:0]       match1,
  output logic [DEPTH-1:0]       match2
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_nxt;

  assign wr_nxt = wr_ptr + PTR_W'(1);
  assign head   = mem[rd_ptr];

  // Pointers, occupancy flags and count; DEPTH is a power of two so pointers wrap naturally.
  // A pop and a push never touch the same slot: pushes need two free slots, pops need one full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
      end
      if (push_n != 2'd0) begin
        vld[wr_ptr] <= 1'b1;
      end
      if (push_n == 2'd2) begin
        vld[wr_nxt] <= 1'b1;
      end
      rd_ptr <= rd_ptr + PTR_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      count  <= count + CNT_W'(push_n) - CNT_W'(pop);
    end
  end

  // Entry payload storage; only meaningful where vld is set.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      mem[wr_ptr] <= push_a;
    end
    if (push_n == 2'd2) begin
      mem[wr_nxt] <= push_b;
    end
  end

  // Per-entry destination compare for decode hazard lookup.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      match1[i] = vld[i] && (mem[i].rd == cmp_addr1);
      match2[i] = vld[i] && (mem[i].rd == cmp_addr2);
    end
  end

endmodule

// File: rtl/wb_serializer.sv
// Writeback serializer: queues up to two retiring results per cycle (lane 0 older)
// and drains one register-file write per cycle onto port 3 (lane 0) or port 6 (lane 1).
//   clk, rst                   : clock, asynchronous active-high reset
//   in0_* / in1_*              : lane results (valid, destination, data)
//   in_ready                   : both lanes accepted this cycle (combinational)
//   WE3/AD3/WD3, WE6/AD6/WD6   : registered reg-file write ports; AD3 mirrors AD6 on port-6 writes
//   chk_addr1/2, chk_hit1/2    : decode pending-write hazard query (combinational)
//   count                      : occupied queue entries
//   empty                      : nothing queued and no write being driven
// Build option WB_COALESCE_EN: a same-cycle lane pair with equal nonzero rd enqueues only
// the lane-1 (younger) result.
module wb_serializer
  import wb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = WB_ADDR_W,
  parameter int unsigned DATA_WIDTH    = WB_DATA_W,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in0_valid,
  input  logic [ADDRESS_WIDTH-1:0] in0_rd,
  input  logic [DATA_WIDTH-1:0]    in0_data,
  input  logic                     in1_valid,
  input  logic [ADDRESS_WIDTH-1:0] in1_rd,
  input  logic [DATA_WIDTH-1:0]    in1_data,
  output logic                     in_ready,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    WD3,
  output logic                     WE6,
  output logic [ADDRESS_WIDTH-1:0] AD6,
  output logic [DATA_WIDTH-1:0]    WD6,
  input  logic [ADDRESS_WIDTH-1:0] chk_addr1,
  input  logic [ADDRESS_WIDTH-1:0] chk_addr2,
  output logic                     chk_hit1,
  output logic                     chk_hit2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             acc0;
  logic             acc1;
  logic             coalesce;
  logic             push0;
  logic [1:0]       push_n;
  logic             pop;
  wb_entry_t        ent0;
  wb_entry_t        ent1;
  wb_entry_t        push_a;
  wb_entry_t        head;
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;
  logic             out_hit1;
  logic             out_hit2;
  logic             in_hit1;
  logic             in_hit2;

  // Admission ignores the same-cycle pop so the producer sees a stable ready.
  assign in_ready = (count <= CNT_W'(DEPTH - 2));

  // Accepted, non-x0 results from each lane.
  assign acc0 = in_ready && in0_valid && (WB_ADDR_W'(in0_rd) != REG_ZERO);
  assign acc1 = in_ready && in1_valid && (WB_ADDR_W'(in1_rd) != REG_ZERO);

`ifdef WB_COALESCE_EN
  // The older write to the same rd would be overwritten immediately; keep only the younger.
  assign coalesce = acc0 && acc1 && (in0_rd == in1_rd);
`else
  assign coalesce = 1'b0;
`endif

  assign push0  = acc0 && !coalesce;
  assign push_n = {1'b0, push0} + {1'b0, acc1};

  assign ent0 = '{lane: LANE0, rd: WB_ADDR_W'(in0_rd), data: WB_DATA_W'(in0_data)};
  assign ent1 = '{lane: LANE1, rd: WB_ADDR_W'(in1_rd), data: WB_DATA_W'(in1_data)};

  // Compact pushes so a lone lane-1 result takes the first free slot.
  assign push_a = push0 ? ent0 : ent1;

  assign pop = (count != '0);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_n    (push_n),
    .push_a    (push_a),
    .push_b    (ent1),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .cmp_addr1 (WB_ADDR_W'(chk_addr1)),
    .cmp_addr2 (WB_ADDR_W'(chk_addr2)),
    .match1    (match1),
    .match2    (match2)
  );

  // Output steering: lane tag selects the port; port-6 writes also drive AD3 for the
  // reg file's port-6 gating on AD3 != 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WE3 <= 1'b0;
      AD3 <= '0;
      WD3 <= '0;
      WE6 <= 1'b0;
      AD6 <= '0;
      WD6 <= '0;
    end else if (pop && (head.lane == LANE0)) begin
      WE3 <= 1'b1;
      AD3 <= ADDRESS_WIDTH'(head.rd);
      WD3 <= DATA_WIDTH'(head.data);
      WE6 <= 1'b0;
      AD6 <= '0;
      WD6 <= '0;
    end else if (pop) begin
      WE3 <= 1'b0;
      AD3 <= ADDRESS_WIDTH'(head.rd);
      WD3 <= '0;
      WE6 <= 1'b1;
      AD6 <= ADDRESS_WIDTH'(head.rd);
      WD6 <= DATA_WIDTH'(head.data);
    end else begin
      WE3 <= 1'b0;
      AD3 <= '0;
      WD3 <= '0;
      WE6 <= 1'b0;
      AD6 <= '0;
      WD6 <= '0;
    end
  end

  // Hazard sources: queued entries, the write on the ports now, and this cycle's inputs.
  assign out_hit1 = (WE3 && (AD3 == chk_addr1)) || (WE6 && (AD6 == chk_addr1));
  assign out_hit2 = (WE3 && (AD3 == chk_addr2)) || (WE6 && (AD6 == chk_addr2));
  assign in_hit1  = (acc0 && (in0_rd == chk_addr1)) || (acc1 && (in1_rd == chk_addr1));
  assign in_hit2  = (acc0 && (in0_rd == chk_addr2)) || (acc1 && (in1_rd == chk_addr2));

  assign chk_hit1 = (chk_addr1 != '0) && ((|match1) || out_hit1 || in_hit1);
  assign chk_hit2 = (chk_addr2 != '0) && ((|match2) || out_hit2 || in_hit2);

  assign empty = (count == '0) && !WE3 && !WE6;

endmodule

// File: tb/tb_wb_serializer.sv
// Self-checking bench for wb_serializer: directed scenarios plus random traffic,
// checked against a queue-based model of the write stream and a register-file image.
module tb_wb_serializer;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          in0_valid, in1_valid;
  logic [AW-1:0] in0_rd, in1_rd;
  logic [DW-1:0] in0_data, in1_data;
  logic          in_ready;
  logic          WE3, WE6;
  logic [AW-1:0] AD3, AD6;
  logic [DW-1:0] WD3, WD6;
  logic [AW-1:0] chk_addr1, chk_addr2;
  logic          chk_hit1, chk_hit2;
  logic [CW-1:0] count;
  logic          empty;

  wb_serializer #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_rd    (in0_rd),
    .in0_data  (in0_data),
    .in1_valid (in1_valid),
    .in1_rd    (in1_rd),
    .in1_data  (in1_data),
    .in_ready  (in_ready),
    .WE3       (WE3),
    .AD3       (AD3),
    .WD3       (WD3),
    .WE6       (WE6),
    .AD6       (AD6),
    .WD6       (WD6),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_hit1  (chk_hit1),
    .chk_hit2  (chk_hit2),
    .count     (count),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          lane;
    int unsigned rd;
    logic [31:0] data;
  } ent_t;

  int          n_tests;
  int          n_fail;
  ent_t        mq[$];
  bit          ov;
  ent_t        oe;
  logic [31:0] rf_dut [32];
  logic [31:0] rf_exp [32];
  bit          last_rdy;
  int unsigned peak;
  int          n_w9;
  logic [31:0] w9_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_hit(input logic [4:0] a, input bit a0, input logic [4:0] r0,
                                 input bit a1, input logic [4:0] r1);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == 32'(a)) return 1'b1;
    if (ov && oe.rd == 32'(a)) return 1'b1;
    if (a0 && r0 == a) return 1'b1;
    if (a1 && r1 == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic rf_commit(input logic [4:0] a, input logic [31:0] d);
    rf_dut[a] = d;
    if (a == 5'd9) begin
      if (n_w9 == 0) w9_first = d;
      n_w9++;
    end
  endtask

  // One clock cycle: drive at posedge+1, check combinational outputs, commit the
  // current port write at negedge, then advance the model and check registered outputs.
  task automatic step(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] r1, input logic [31:0] d1,
                      input logic [4:0] q1, input logic [4:0] q2);
    bit          rdy, a0, a1, coal;
    logic        e_we3, e_we6;
    logic [31:0] e_ad3, e_ad6, e_wd3, e_wd6;
    in0_valid = v0; in0_rd = r0; in0_data = d0;
    in1_valid = v1; in1_rd = r1; in1_data = d1;
    chk_addr1 = q1; chk_addr2 = q2;
    #1;
    rdy  = (int'(DEPTH) - mq.size()) >= 2;
    a0   = rdy && v0 && (r0 != 5'd0);
    a1   = rdy && v1 && (r1 != 5'd0);
    coal = 1'b0;
`ifdef WB_COALESCE_EN
    coal = a0 && a1 && (r0 == r1);
`endif
    last_rdy = rdy;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("chk_hit1", 32'(chk_hit1), 32'(exp_hit(q1, a0, r0, a1, r1)));
    chk("chk_hit2", 32'(chk_hit2), 32'(exp_hit(q2, a0, r0, a1, r1)));

    @(negedge clk);
    chk("single_we", 32'(WE3 & WE6), 32'd0);
    if (WE3) rf_commit(AD3, WD3);
    if (WE6) rf_commit(AD6, WD6);

    @(posedge clk);
    #1;
    if (mq.size() > 0) begin
      ov = 1'b1;
      oe = mq.pop_front();
    end else begin
      ov = 1'b0;
    end
    if (a0 && !coal) begin
      mq.push_back('{lane: 1'b0, rd: 32'(r0), data: d0});
      rf_exp[r0] = d0;
    end
    if (a1) begin
      mq.push_back('{lane: 1'b1, rd: 32'(r1), data: d1});
      rf_exp[r1] = d1;
    end
    e_we3 = 1'b0; e_we6 = 1'b0;
    e_ad3 = '0; e_ad6 = '0; e_wd3 = '0; e_wd6 = '0;
    if (ov && oe.lane == 1'b0) begin
      e_we3 = 1'b1; e_ad3 = oe.rd; e_wd3 = oe.data;
    end else if (ov) begin
      e_we6 = 1'b1; e_ad6 = oe.rd; e_wd6 = oe.data; e_ad3 = oe.rd;
    end
    chk("WE3", 32'(WE3), 32'(e_we3));
    chk("AD3", 32'(AD3), e_ad3);
    chk("WD3", WD3, e_wd3);
    chk("WE6", 32'(WE6), 32'(e_we6));
    chk("AD6", 32'(AD6), e_ad6);
    chk("WD6", WD6, e_wd6);
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0 && !ov));
    if (32'(count) > peak) peak = 32'(count);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  task automatic chk_ports_zero(input string tag);
    chk({tag, "_WE3"}, 32'(WE3), 32'd0);
    chk({tag, "_WE6"}, 32'(WE6), 32'd0);
    chk({tag, "_AD3"}, 32'(AD3), 32'd0);
    chk({tag, "_AD6"}, 32'(AD6), 32'd0);
    chk({tag, "_WD3"}, WD3, 32'd0);
    chk({tag, "_WD6"}, WD6, 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  s_rd [20];
    logic [31:0] s_d  [20];
    int          idx;
    int          cyc;
    bit          saw_stall;

    n_tests = 0; n_fail = 0;
    ov = 1'b0; peak = 0; n_w9 = 0; w9_first = '0;
    for (int i = 0; i < 32; i++) begin
      rf_dut[i] = '0;
      rf_exp[i] = '0;
    end
    rst = 1'b1;
    in0_valid = 1'b0; in0_rd = '0; in0_data = '0;
    in1_valid = 1'b0; in1_rd = '0; in1_data = '0;
    chk_addr1 = '0; chk_addr2 = '0;

    // Reset state
    #12;
    chk_ports_zero("reset");
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single lane-0 result: written on port 3 one cycle after acceptance
    step(1'b1, 5'd5, 32'hA, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    chk("t1_no_write_yet", 32'(WE3), 32'd0);
    idle(1);
    chk("t1_we3", 32'(WE3), 32'd1);
    chk("t1_ad3", 32'(AD3), 32'd5);
    chk("t1_wd3", WD3, 32'hA);
    idle(1);
    chk("t1_done_we3", 32'(WE3), 32'd0);
    chk("t1_done_empty", 32'(empty), 32'd1);

    // Dual issue: lane 0 on port 3, then lane 1 on port 6 with AD3 mirrored
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd3, 5'd4);
    idle(1);
    chk("t2_ad3_first", 32'(AD3), 32'd3);
    idle(1);
    chk("t2_we6", 32'(WE6), 32'd1);
    chk("t2_ad6", 32'(AD6), 32'd4);
    chk("t2_ad3_mirror", 32'(AD3), 32'd4);
    chk("t2_we3_off", 32'(WE3), 32'd0);
    idle(1);

    // x0 result discarded; lone lane-1 entry; rs1 query of x0 never hits
    step(1'b1, 5'd0, 32'hFF, 1'b1, 5'd7, 32'h1, 5'd0, 5'd7);
    chk("t3_one_entry", 32'(count), 32'd1);
    idle(1);
    chk("t3_we6", 32'(WE6), 32'd1);
    chk("t3_ad6", 32'(AD6), 32'd7);
    idle(2);

    // Same rd on both lanes
    peak = 0; n_w9 = 0;
    step(1'b1, 5'd9, 32'd1, 1'b1, 5'd9, 32'd2, 5'd9, 5'd0);
    idle(4);
    chk("t5_x9_final", rf_dut[9], 32'd2);
`ifdef WB_COALESCE_EN
    chk("t5_peak", peak, 32'd1);
    chk("t5_n_writes", 32'(n_w9), 32'd1);
    chk("t5_first", w9_first, 32'd2);
`else
    chk("t5_peak", peak, 32'd2);
    chk("t5_n_writes", 32'(n_w9), 32'd2);
    chk("t5_first", w9_first, 32'd1);
`endif

    // Sustained dual issue, 20 results across pointer wrap; producer holds on stall
    for (int i = 0; i < 20; i++) begin
      s_rd[i] = 5'($urandom_range(1, 31));
      s_d[i]  = $urandom;
    end
    idx = 0; cyc = 0; saw_stall = 1'b0;
    while (idx < 20 && cyc < 100) begin
      step(1'b1, s_rd[idx], s_d[idx], 1'b1, s_rd[idx+1], s_d[idx+1],
           s_rd[idx], 5'($urandom_range(0, 31)));
      if (last_rdy) idx += 2;
      else saw_stall = 1'b1;
      cyc++;
    end
    chk("stream_all_accepted", 32'(idx), 32'd20);
    chk("stream_backpressure", 32'(saw_stall), 32'd1);
    idle(6);

    // Random mixed traffic with small register range to provoke hazards and x0
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(6);

    // Register-file image after full drain
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("rf_x%0d", i), rf_dut[i], rf_exp[i]);
    end

    // Pending rd 6 hazard, then reset in the middle of draining
    step(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h67, 5'd0, 5'd6);
    step(1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC, 5'd0, 5'd6);
    in0_valid = 1'b0; in1_valid = 1'b0;
    #1;
    chk("hz_pre_we3", 32'(WE3), 32'd1);
    chk("hz_hit2", 32'(chk_hit2), 32'd1);
    rst = 1'b1;
    #1;
    chk_ports_zero("mid_rst");
    chk("mid_rst_hit2", 32'(chk_hit2), 32'd0);
    mq.delete();
    ov = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Recovery after reset
    step(1'b1, 5'd2, 32'h1234, 1'b1, 5'd6, 32'h5678, 5'd6, 5'd2);
    idle(4);
    chk("post_rst_x6", rf_dut[6], 32'h5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
